param_mac_array: RTL and testbench

PARAM_MAC_ARRAY -- requirements
Module: param_mac_array

---
 rtl/param_mac_array.sv | 124 ++++++++++++
 tb/tb_param_mac_array.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/param_mac_array.sv
// param_mac_array: LANES-wide signed dot-product engine with a two-stage multiply/accumulate pipeline.
// Define MAC_ARRAY_SAT_EN for saturating accumulation with sticky per-lane sat flags; otherwise sums wrap.
module param_mac_array #(
  parameter int LANES  = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int LEN_W  = 8
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      clear_i,
  input  logic [LEN_W-1:0]          len_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [LANES*DATA_W-1:0]   data_i,
  input  logic [LANES*DATA_W-1:0]   weight_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [LANES*ACC_W-1:0]    result_o,
  output logic [LANES-1:0]          sat_o
);
  typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, HOLD} state_t;
  state_t state, state_n;
  logic run, accept, first_b, last_b, p_valid, p_first, p_last;
  logic [LEN_W-1:0] len_q, len_eff, cnt;
  logic [LANES-1:0][2*DATA_W-1:0] prod, prod_c;
  logic [LANES-1:0][ACC_W-1:0] acc, acc_n;
  logic [LANES-1:0] sat_acc, sat_n;
  // ready is held low until the first edge after reset release
  assign in_ready_o = run && (state == IDLE || state == ACCUM);
  assign accept     = in_valid_i && in_ready_o && !clear_i;
  assign len_eff    = (len_i == '0) ? LEN_W'(1) : len_i;
  always_comb begin
    state_n = state;
    first_b = 1'b0;
    last_b  = 1'b0;
    unique case (state)
      IDLE: if (accept) begin
        first_b = 1'b1;
        last_b  = (len_eff == LEN_W'(1));
        state_n = last_b ? FLUSH : ACCUM;
      end
      ACCUM: if (accept) begin
        last_b  = (cnt == len_q - LEN_W'(1));
        state_n = last_b ? FLUSH : ACCUM;
      end
      FLUSH: state_n = p_last ? HOLD : FLUSH;
      HOLD:  state_n = out_ready_i ? IDLE : HOLD;
      default: state_n = IDLE;
    endcase
    if (clear_i) state_n = IDLE;
  end
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [DATA_W-1:0] d, w;
    logic signed [ACC_W-1:0] ext, base;
    logic ovf;
    assign d         = data_i[i*DATA_W +: DATA_W];
    assign w         = weight_i[i*DATA_W +: DATA_W];
    assign prod_c[i] = (2*DATA_W)'(d) * (2*DATA_W)'(w);
    assign ext       = ACC_W'($signed(prod[i]));
    assign base      = p_first ? '0 : $signed(acc[i]);
`ifdef MAC_ARRAY_SAT_EN
    logic signed [ACC_W:0] sum;
    assign sum      = (ACC_W+1)'(base) + (ACC_W+1)'(ext);
    assign ovf      = sum[ACC_W] != sum[ACC_W-1];
    assign acc_n[i] = !ovf ? sum[ACC_W-1:0] :
                      sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
`else
    assign ovf      = 1'b0;
    assign acc_n[i] = base + ext;
`endif
    assign sat_n[i] = (!p_first && sat_acc[i]) || ovf;
  end
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      run         <= 1'b0;
      state       <= IDLE;
      len_q       <= '0;
      cnt         <= '0;
      p_valid     <= 1'b0;
      p_first     <= 1'b0;
      p_last      <= 1'b0;
      prod        <= '0;
      acc         <= '0;
      sat_acc     <= '0;
      out_valid_o <= 1'b0;
      result_o    <= '0;
      sat_o       <= '0;
    end else begin
      run   <= 1'b1;
      state <= state_n;
      if (clear_i) begin
        len_q       <= '0;
        cnt         <= '0;
        p_valid     <= 1'b0;
        p_first     <= 1'b0;
        p_last      <= 1'b0;
        prod        <= '0;
        acc         <= '0;
        sat_acc     <= '0;
        out_valid_o <= 1'b0;
        result_o    <= '0;
        sat_o       <= '0;
      end else begin
        if (accept) cnt <= first_b ? LEN_W'(1) : cnt + LEN_W'(1);
        if (first_b) len_q <= len_eff;
        p_valid <= accept;
        p_first <= first_b;
        p_last  <= last_b;
        if (accept) prod <= prod_c;
        if (out_valid_o && out_ready_i) out_valid_o <= 1'b0;
        if (p_valid) begin
          acc     <= acc_n;
          sat_acc <= sat_n;
        end
        if (p_valid && p_last) begin
          result_o    <= acc_n;
          sat_o       <= sat_n;
          out_valid_o <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_param_mac_array.sv
// tb_param_mac_array: directed checks of the default MAC array plus a 16-bit accumulator instance for overflow behaviour.
module tb_param_mac_array;
  logic clk = 1'b0, rstn = 1'b0, clear = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [7:0] len = 8'd1;
  logic [31:0] data = '0, weight = '0;
  logic in_ready, out_valid, in_ready16, out_valid16;
  logic [127:0] result;
  logic [63:0] result16;
  logic [3:0] sat, sat16;
  int errs = 0, checks = 0;
  param_mac_array dut (
    .clk_i(clk), .rstn_i(rstn), .clear_i(clear), .len_i(len), .in_valid_i(in_valid),
    .in_ready_o(in_ready), .data_i(data), .weight_i(weight), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .result_o(result), .sat_o(sat));
  param_mac_array #(.ACC_W(16)) dut16 (
    .clk_i(clk), .rstn_i(rstn), .clear_i(clear), .len_i(len), .in_valid_i(in_valid),
    .in_ready_o(in_ready16), .data_i(data), .weight_i(weight), .out_valid_o(out_valid16),
    .out_ready_i(out_ready), .result_o(result16), .sat_o(sat16));
  always #5 clk = ~clk;
  function automatic int r32(int l);
    return int'($signed(result[l*32 +: 32]));
  endfunction
  function automatic int r16(int l);
    return int'($signed(result16[l*16 +: 16]));
  endfunction
  task automatic set_lane(int l, int d, int w);
    data[l*8 +: 8]   = 8'(d);
    weight[l*8 +: 8] = 8'(w);
  endtask
  task automatic beat(int d, int w);
    for (int l = 0; l < 4; l++) set_lane(l, d, w);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask
  task automatic step;
    @(posedge clk); #1;
  endtask
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic test_reset;
    #12;
    checks++; if (in_ready !== 1'b0) begin errs++; $display("FAIL rst_in_ready: got %b expected 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    checks++; if (result !== '0 || sat !== '0) begin errs++; $display("FAIL rst_result: got %h/%h expected 0", result, sat); end
    @(negedge clk); rstn = 1'b1;
    step();
    checks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL rst_release_ready: got %b expected 1", in_ready); end
  endtask
  task automatic test_basic;
    len = 8'd4;
    for (int b = 0; b < 4; b++) beat(3, 5);
    chk("basic_valid_t1", int'(out_valid), 0);
    step();
    chk("basic_valid_t2", int'(out_valid), 1);
    for (int l = 0; l < 4; l++) chk($sformatf("basic_lane%0d", l), r32(l), 60);
    chk("basic_sat", int'(sat), 0);
    step();
    chk("basic_release_valid", int'(out_valid), 0);
    chk("basic_release_ready", int'(in_ready), 1);
  endtask
  task automatic test_len1;
    len = 8'd1;
    set_lane(0, -128, -128); set_lane(1, -128, 127); set_lane(2, 0, 0); set_lane(3, 0, 0);
    in_valid = 1'b1; step(); in_valid = 1'b0;
    step();
    chk("len1_valid", int'(out_valid), 1);
    chk("len1_lane0", r32(0), 16384);
    chk("len1_lane1", r32(1), -16256);
    step();
  endtask
  task automatic test_len0;
    len = 8'd0;
    beat(6, 7);
    step();
    chk("len0_valid", int'(out_valid), 1);
    chk("len0_lane3", r32(3), 42);
    step();
  endtask
  task automatic test_gaps;
    len = 8'd3;
    beat(2, 3); step();
    beat(4, 5); step(); step();
    chk("gaps_no_early_valid", int'(out_valid), 0);
    beat(-1, 7);
    step();
    chk("gaps_valid", int'(out_valid), 1);
    chk("gaps_lane2", r32(2), 19);
    step();
  endtask
  task automatic test_hold;
    out_ready = 1'b0;
    len = 8'd2;
    beat(2, 2); beat(2, 2);
    step();
    chk("hold_valid_start", int'(out_valid), 1);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      step();
      chk($sformatf("hold_valid_c%0d", c), int'(out_valid), 1);
      chk($sformatf("hold_ready_c%0d", c), int'(in_ready), 0);
      chk($sformatf("hold_lane0_c%0d", c), r32(0), 8);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("hold_after_valid", int'(out_valid), 0);
    chk("hold_after_ready", int'(in_ready), 1);
    chk("hold_after_lane0", r32(0), 8);
  endtask
  task automatic test_clear;
    len = 8'd4;
    beat(3, 5); beat(3, 5);
    clear = 1'b1;
    for (int l = 0; l < 4; l++) set_lane(l, 9, 9);
    in_valid = 1'b1;
    step();
    clear = 1'b0; in_valid = 1'b0;
    chk("clear_valid", int'(out_valid), 0);
    chk("clear_result", int'(result == '0), 1);
    chk("clear_ready", int'(in_ready), 1);
    step(); step();
    len = 8'd2;
    beat(1, 1); beat(1, 1);
    step();
    chk("clear_new_valid", int'(out_valid), 1);
    chk("clear_new_lane0", r32(0), 2);
    chk("clear_new_lane3", r32(3), 2);
    step();
  endtask
  task automatic test_sat;
    len = 8'd3;
    for (int b = 0; b < 3; b++) beat(127, 127);
    step();
    chk("sat_valid16", int'(out_valid16), 1);
    chk("sat_wide_lane0", r32(0), 48387);
`ifdef MAC_ARRAY_SAT_EN
    chk("sat_lane0_16", r16(0), 32767);
    chk("sat_flag16", int'(sat16), 15);
`else
    chk("wrap_lane0_16", r16(0), -17149);
    chk("wrap_flag16", int'(sat16), 0);
`endif
    step();
  endtask
  task automatic test_async_reset;
    len = 8'd4;
    beat(3, 5); beat(3, 5);
    #2 rstn = 1'b0;
    #1;
    chk("arst_ready", int'(in_ready), 0);
    chk("arst_valid", int'(out_valid), 0);
    chk("arst_result", int'(result == '0), 1);
    @(negedge clk); rstn = 1'b1;
    step();
    len = 8'd1;
    beat(2, 2);
    step();
    chk("arst_new_valid", int'(out_valid), 1);
    chk("arst_new_lane1", r32(1), 4);
    step();
  endtask
  initial begin
    test_reset();
    test_basic();
    test_len1();
    test_len0();
    test_gaps();
    test_hold();
    test_clear();
    test_sat();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
